// File: rtl/dcb_cfg_pkg.sv
// Shared definitions for the data connection block configuration path:
// loader FSM states, CRC-8 constants and the configuration width helper.
package dcb_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  // Configuration bits for a block with w wires per side and din/dout MAC words.
  function automatic int unsigned conf_width(input int unsigned w,
                                             input int unsigned din,
                                             input int unsigned dout);
    return w * (din + dout);
  endfunction

endpackage

// File: rtl/dcb_cfg_crc8.sv
// Per-beat CRC-8 accumulator (poly 0x07, init 0x00), data bits taken LSB first.
module dcb_cfg_crc8
  import dcb_cfg_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] data,
  output logic [7:0] crc
);

  logic [7:0] crc_q;
  logic [7:0] crc_next;

  // Fold one 8-bit beat into the running remainder, bit 0 first.
  always_comb begin
    crc_next = crc_q;
    for (int unsigned i = 0; i < 8; i++) begin
      if (crc_next[7] ^ data[i]) crc_next = {crc_next[6:0], 1'b0} ^ CRC8_POLY;
      else                       crc_next = {crc_next[6:0], 1'b0};
    end
  end

  // Remainder register: cleared on reset or new load, updated per accepted beat.
  always_ff @(posedge clk) begin
    if (!rst || clr) crc_q <= CRC8_INIT;
    else if (en)     crc_q <= crc_next;
  end

  assign crc = crc_q;

endmodule

// File: rtl/dcb_config_loader.sv
// Double-buffered configuration loader for a data connection block.
// Beats are shifted into a staging register; the active c bus is replaced
// atomically and announced with a one-cycle cset/done pulse.
// Optional macro DCB_CONFIG_CRC_EN: adds a trailing CRC-8 beat that must
// match before the staging register is committed.
module dcb_config_loader
  import dcb_cfg_pkg::*;
#(
  parameter int unsigned W          = 192,
  parameter int unsigned DATAIN     = 8,
  parameter int unsigned DATAOUT    = 8,
  parameter int unsigned CONF_WIDTH = conf_width(W, DATAIN, DATAOUT),
  parameter int unsigned CHUNK      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_start,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CHUNK-1:0]      cfg_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [CONF_WIDTH-1:0] c,
  output logic                  cset
);

  localparam int unsigned NBEATS = CONF_WIDTH / CHUNK;
  localparam int unsigned CW     = $clog2(NBEATS + 1);
`ifdef DCB_CONFIG_CRC_EN
  localparam int unsigned LAST   = NBEATS;
`else
  localparam int unsigned LAST   = NBEATS - 1;
`endif

  state_t                state, state_next;
  logic [CW-1:0]         cnt, cnt_next;
  logic [CONF_WIDTH-1:0] staging, staging_next;
  logic [CONF_WIDTH-1:0] c_q, c_next;
  logic                  err_q, err_next;
  logic                  cset_q, cset_next;

`ifdef DCB_CONFIG_CRC_EN
  logic [7:0] crc;
  logic       crc_clr;
  logic       crc_en;

  if (CHUNK != 8) begin : g_chunk_check
    $error("dcb_config_loader: CRC beat requires CHUNK == 8");
  end

  assign crc_clr = cfg_start && (state == IDLE || state == LOAD);
  assign crc_en  = (state == LOAD) && cfg_valid && !cfg_start;

  dcb_cfg_crc8 u_crc (
    .clk  (clk),
    .rst  (rst),
    .clr  (crc_clr),
    .en   (crc_en),
    .data (cfg_data[7:0]),
    .crc  (crc)
  );
`endif

  // State, counter, staging, active config and status registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      staging <= '0;
      c_q     <= '0;
      err_q   <= 1'b0;
      cset_q  <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      staging <= staging_next;
      c_q     <= c_next;
      err_q   <= err_next;
      cset_q  <= cset_next;
    end
  end

  // Next-state logic: start/abort handling, beat capture and commit.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    staging_next = staging;
    c_next       = c_q;
    err_next     = err_q;
    cset_next    = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_start) begin
          state_next   = LOAD;
          cnt_next     = '0;
          staging_next = '0;
          err_next     = 1'b0;
        end
      end
      LOAD: begin
        err_next = 1'b0;
        if (cfg_start) begin
          // Abort wins over a coincident beat; err flags only this restart cycle.
          cnt_next     = '0;
          staging_next = '0;
          err_next     = 1'b1;
        end else if (cfg_valid) begin
          for (int unsigned k = 0; k < NBEATS; k++) begin
            if (cnt == CW'(k)) staging_next[k*CHUNK +: CHUNK] = cfg_data;
          end
          cnt_next = cnt + CW'(1);
          if (cnt == CW'(LAST)) begin
`ifdef DCB_CONFIG_CRC_EN
            if (cfg_data[7:0] == crc) begin
              state_next = COMMIT;
            end else begin
              state_next = IDLE;
              err_next   = 1'b1;
            end
`else
            state_next = COMMIT;
`endif
          end
        end
      end
      COMMIT: begin
        c_next     = staging;
        cset_next  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign cfg_ready = (state == LOAD);
  assign busy      = (state != IDLE);
  assign c         = c_q;
  assign cset      = cset_q;
  assign done      = cset_q;
  assign err       = err_q;

endmodule
